// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolver.
// Contents: PC width, branch-type encodings, resolver FSM states, and a
// helper that selects the condition flag for a branch type.
package branch_resolve_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    BR_BEQZ = 2'b00,
    BR_BNEZ = 2'b01,
    BR_BLTZ = 2'b10,
    BR_BGEZ = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REDIRECT = 2'b01,
    FLUSH    = 2'b10
  } br_state_e;

  // Pick the decode-stage flag that matches the branch type.
  // The flags are trusted as given and are not checked against each other.
  function automatic logic sel_cond(input br_type_e t, input logic z,
                                    input logic nz, input logic lt,
                                    input logic gte);
    unique case (t)
      BR_BEQZ: sel_cond = z;
      BR_BNEZ: sel_cond = nz;
      BR_BLTZ: sel_cond = lt;
      default: sel_cond = gte;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Decode <-> branch resolver bundle.
//   master : decode side; drives the branch, flags, PC/imm and stall.
//   slave  : resolver side; drives redirect, redirect_pc, flush, busy
//            and the statistics counters.
// CNT_W sets the statistics counter width.
interface branch_resolve_if #(parameter int CNT_W = 16);
  import branch_resolve_pkg::*;

  logic             br_valid;
  logic [1:0]       br_type;
  logic             Rs_zero;
  logic             Rs_n_zero;
  logic             Rs_lt_zero;
  logic             Rs_gte_zero;
  logic [PC_W-1:0]  pc_plus2;
  logic [PC_W-1:0]  imm;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output br_valid, br_type, Rs_zero, Rs_n_zero, Rs_lt_zero, Rs_gte_zero,
           pc_plus2, imm, stall,
    input  redirect, redirect_pc, flush, busy, br_count, taken_count
  );

  modport slave (
    input  br_valid, br_type, Rs_zero, Rs_n_zero, Rs_lt_zero, Rs_gte_zero,
           pc_plus2, imm, stall,
    output redirect, redirect_pc, flush, busy, br_count, taken_count
  );

endinterface

// File: rtl/branch_resolve_flush_ctr.sv
// br_flush_ctr: loadable down-counter used to time the flush window.
// Ports:
//   clk, rst  : clock, async active-high reset
//   load      : load load_val this cycle (has priority over dec)
//   load_val  : value to load
//   dec       : decrement this cycle
//   zero_o    : the count after this edge will be zero
module br_flush_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (dec) cnt_d = cnt_q - W'(1);
  end

  // Look-ahead flag so the FSM can leave FLUSH on the 1 -> 0 step.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches under a static not-taken
// policy. A taken branch registers a one-cycle redirect to pc_plus2 + imm
// and holds flush for FLUSH_CYCLES cycles (redirect cycle included).
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : branch_resolve_if.slave (branch in, redirect/flush out)
// Parameters: FLUSH_CYCLES (1..15), CNT_W (statistics counter width).
// Optional: define BRANCH_STATS_EN to build the saturating br_count /
// taken_count counters; otherwise both read constant 0.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus
);

  localparam int CTR_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e       state_q, state_d;
  logic            redirect_q, redirect_d;
  logic            flush_q, flush_d;
  logic            busy_q, busy_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic            ctr_load, ctr_dec, ctr_zero;
  logic            accept, cond;
  logic [PC_W-1:0] target;

  assign accept = bus.br_valid & ~bus.stall & (state_q == IDLE);
  assign cond   = sel_cond(br_type_e'(bus.br_type), bus.Rs_zero,
                           bus.Rs_n_zero, bus.Rs_lt_zero, bus.Rs_gte_zero);
  assign target = bus.pc_plus2 + bus.imm;  // carry-out dropped: wraps mod 2^16

  br_flush_ctr #(.W(CTR_W)) u_flush_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CTR_W'(FLUSH_CYCLES - 1)),
    .dec      (ctr_dec),
    .zero_o   (ctr_zero)
  );

  // Outputs are registered: the _d values here are what the block shows
  // during the cycle after the edge.
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    flush_d       = flush_q;
    busy_d        = busy_q;
    redirect_pc_d = redirect_pc_q;
    ctr_load      = 1'b0;
    ctr_dec       = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        busy_d  = 1'b0;
        if (accept && cond) begin
          state_d       = REDIRECT;
          redirect_d    = 1'b1;
          flush_d       = 1'b1;
          busy_d        = 1'b1;
          redirect_pc_d = target;
        end
      end
      REDIRECT: begin
        ctr_load = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          flush_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      FLUSH: begin
        ctr_dec = 1'b1;
        if (ctr_zero) begin
          state_d = IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.flush       = flush_q;
  assign bus.busy        = busy_q;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  // Saturating counters: stop at all-ones.
  always_comb begin
    br_cnt_d = br_cnt_q;
    tk_cnt_d = tk_cnt_q;
    if (accept && (br_cnt_q != '1))         br_cnt_d = br_cnt_q + CNT_W'(1);
    if (accept && cond && (tk_cnt_q != '1)) tk_cnt_d = tk_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign bus.br_count    = br_cnt_q;
  assign bus.taken_count = tk_cnt_q;
`else
  assign bus.br_count    = {CNT_W{1'b0}};
  assign bus.taken_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve (FLUSH_CYCLES = 2, CNT_W = 4).
// Counter expectations follow BRANCH_STATS_EN: counts when defined, 0 otherwise.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int CW = 4;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_if #(.CNT_W(CW)) bus ();

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int exp_br = 0;
  int exp_tk = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input logic r, input logic f,
                         input logic b, input logic [15:0] pc);
    chk({tag, ".redirect"}, 32'(bus.redirect), 32'(r));
    chk({tag, ".flush"},    32'(bus.flush),    32'(f));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
    chk({tag, ".pc"},       32'(bus.redirect_pc), 32'(pc));
  endtask

  task automatic chk_cnt(input string tag);
    int eb, et;
    eb = STATS ? exp_br : 0;
    et = STATS ? exp_tk : 0;
    chk({tag, ".br_count"},    32'(bus.br_count),    32'(eb));
    chk({tag, ".taken_count"}, 32'(bus.taken_count), 32'(et));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fl = {gte, lt, nz, z}
  task automatic drive(input logic v, input logic [1:0] t, input logic [3:0] fl,
                       input logic [15:0] pc, input logic [15:0] im);
    bus.br_valid    = v;
    bus.br_type     = t;
    bus.Rs_zero     = fl[0];
    bus.Rs_n_zero   = fl[1];
    bus.Rs_lt_zero  = fl[2];
    bus.Rs_gte_zero = fl[3];
    bus.pc_plus2    = pc;
    bus.imm         = im;
  endtask

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst_hold", 0, 0, 0, 16'h0000);
    rst = 1'b0;
    step();
    chk_out("rst_rel", 0, 0, 0, 16'h0000);
    chk_cnt("rst_rel");

    // BEQZ taken: 0x0010 + 0x0006
    drive(1'b1, BR_BEQZ, 4'b1001, 16'h0010, 16'h0006);
    step(); exp_br++; exp_tk++;
    chk_out("beqz_redir", 1, 1, 1, 16'h0016);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    step();
    chk_out("beqz_flush", 0, 1, 1, 16'h0016);
    step();
    chk_out("beqz_idle", 0, 0, 0, 16'h0016);

    // BLTZ not taken (Rs >= 0)
    drive(1'b1, BR_BLTZ, 4'b1010, 16'h0030, 16'h0010);
    step(); exp_br++;
    chk_out("bltz_nt", 0, 0, 0, 16'h0016);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);

    // BGEZ taken, backward target
    drive(1'b1, BR_BGEZ, 4'b1010, 16'h0004, 16'hFFF8);
    step(); exp_br++; exp_tk++;
    chk_out("bgez_back", 1, 1, 1, 16'hFFFC);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    step(); step();
    chk_out("bgez_idle", 0, 0, 0, 16'hFFFC);

    // target wraps past 0xFFFF
    drive(1'b1, BR_BEQZ, 4'b1001, 16'hFFFE, 16'h0004);
    step(); exp_br++; exp_tk++;
    chk_out("wrap", 1, 1, 1, 16'h0002);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    step(); step();
    chk_cnt("after_wrap");

    // BNEZ taken held under stall for 3 cycles
    bus.stall = 1'b1;
    drive(1'b1, BR_BNEZ, 4'b1010, 16'h0100, 16'h0020);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("stalled", 0, 0, 0, 16'h0002);
    end
    bus.stall = 1'b0;
    step(); exp_br++; exp_tk++;
    chk_out("unstall", 1, 1, 1, 16'h0120);
    // a second taken branch while busy must be ignored
    drive(1'b1, BR_BEQZ, 4'b1001, 16'h0200, 16'h0002);
    step();
    chk_out("busy_ign", 0, 1, 1, 16'h0120);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    step();
    chk_out("busy_done", 0, 0, 0, 16'h0120);
    chk_cnt("busy_ign");

    // async reset in the middle of FLUSH
    drive(1'b1, BR_BEQZ, 4'b1001, 16'h0040, 16'h0002);
    step();
    chk_out("pre_rst", 1, 1, 1, 16'h0042);
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    step();
    chk_out("pre_rst_fl", 0, 1, 1, 16'h0042);
    #1 rst = 1'b1;
    #1;
    exp_br = 0; exp_tk = 0;
    chk_out("rst_async", 0, 0, 0, 16'h0000);
    chk_cnt("rst_async");
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk_out("rst_resume", 0, 0, 0, 16'h0000);

    // back-to-back not-taken, one accept per cycle
    drive(1'b1, BR_BEQZ, 4'b1010, 16'h0050, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(); exp_br++;
      chk_out("nt_b2b", 0, 0, 0, 16'h0000);
    end
    drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
    chk_cnt("nt_b2b");

    // 17 taken branches: both counters saturate at 15
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, BR_BEQZ, 4'b1001, 16'(i * 2), 16'h0000);
      step();
      chk("sat_redir", 32'(bus.redirect), 32'd1);
      drive(1'b0, BR_BEQZ, 4'b0000, 16'h0, 16'h0);
      step(); step();
    end
    exp_br = 15; exp_tk = 15;
    chk_cnt("saturate");
    chk_out("final", 0, 0, 0, 16'h0020);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Downstream consumer of the decode-stage Rs condition flags (zero / non-zero / negative / non-negative) in the 16-bit pipelined core.
- Selects the flag matching the branch type and computes the target PC.
- Uses a static not-taken policy: a taken branch is a mispredict. The block registers a one-cycle PC redirect and squashes younger fetch/decode slots for a programmable number of cycles.

Parameters:
- FLUSH_CYCLES, 2, total cycles flush is asserted per taken branch (legal range 1..15), redirect cycle included.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- br_valid  in  1  decode holds a conditional branch this cycle.
- br_type  in  2  branch type: 00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ.
- Rs_zero  in  1  Rs == 0.
- Rs_n_zero  in  1  Rs != 0.
- Rs_lt_zero  in  1  Rs[15] == 1.
- Rs_gte_zero  in  1  Rs[15] == 0.
- pc_plus2  in  16  PC of the branch + 2.
- imm  in  16  sign-extended branch displacement.
- stall  in  1  decode stalled; the branch must not be accepted this cycle.
- redirect  out  1  one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  16  branch target, valid while redirect = 1.
- flush  out  1  squash fetch/decode contents this cycle.
- busy  out  1  resolver is in REDIRECT or FLUSH.
- br_count  out  CNT_W  branches accepted (optional feature).
- taken_count  out  CNT_W  taken branches accepted (optional feature).

Behaviour:
- Reset (asynchronous): state = IDLE; redirect, flush, busy = 0; redirect_pc = 0x0000; counters = 0. Reset asserted mid-REDIRECT or mid-FLUSH aborts immediately. After deassertion the block is in IDLE with no pending redirect.
- Accept condition: br_valid & ~stall & state == IDLE.
- cond = flag selected by br_type: 00→Rs_zero, 01→Rs_n_zero, 10→Rs_lt_zero, 11→Rs_gte_zero. Flags are not cross-checked.
- Target = pc_plus2 + imm, modulo 2^16. Carry-out is discarded, so 0xFFFE + 0x0004 gives 0x0002.
- FSM IDLE: on accept with cond = 1, register the target and go to REDIRECT. On accept with cond = 0, stay in IDLE with no output activity.
- FSM REDIRECT (exactly one cycle): redirect = 1, flush = 1, busy = 1. Load flush counter = FLUSH_CYCLES − 1. Next state is FLUSH if FLUSH_CYCLES > 1, otherwise IDLE.
- FSM FLUSH: flush = 1, busy = 1, counter decrements each cycle. Return to IDLE on the cycle the counter reaches 1 → 0.
- Latency: a branch accepted at edge N produces redirect/flush high in cycle N+1. For FLUSH_CYCLES = F, flush is high for exactly F consecutive cycles.
- stall is ignored outside IDLE. Redirect and flush always complete.
- br_valid while busy is ignored: that instruction sits in a squashed slot. It is not queued or counted.
- br_valid while stall = 1 in IDLE is not accepted. The same branch is re-evaluated on the first cycle with stall = 0.
- Back-to-back branches in IDLE with cond = 0 are each accepted, one per cycle.
- redirect_pc holds its last value when redirect = 0.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: br_count increments on every accept; taken_count increments on every accept with cond = 1. Both saturate at 2^CNT_W − 1 and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops are instantiated. The port list is unchanged.

Decomposition:
- Shared package: br_type encodings (BR_BEQZ, BR_BNEZ, BR_BLTZ, BR_BGEZ), FSM state encoding (IDLE, REDIRECT, FLUSH), and the 16-bit PC width constant.
- One sub-module: br_flush_ctr, a loadable down-counter with a zero flag, width ceil(log2(FLUSH_CYCLES)).

Test Plan:
- rst high 3 cycles, then low → redirect = flush = busy = 0, redirect_pc = 0x0000. Pulse rst during FLUSH → outputs drop immediately and IDLE resumes.
- BEQZ, Rs_zero = 1, pc_plus2 = 0x0010, imm = 0x0006, FLUSH_CYCLES = 2 → next cycle redirect = 1, redirect_pc = 0x0016, flush = 1 for 2 cycles, busy = 1 for 2 cycles.
- BLTZ, Rs_gte_zero = 1 (Rs_lt_zero = 0) → no redirect, no flush, state remains IDLE.
- BGEZ taken, pc_plus2 = 0x0004, imm = 0xFFF8 → redirect_pc = 0xFFFC. pc_plus2 = 0xFFFE, imm = 0x0004 → redirect_pc = 0x0002 (wrap).
- Taken BNEZ held with stall = 1 for 3 cycles, then stall = 0 → exactly one redirect, one cycle after stall falls. A second br_valid during FLUSH → ignored, and taken_count increments by 1 only (with BRANCH_STATS_EN).
- With BRANCH_STATS_EN, CNT_W = 4: 17 accepted taken branches → br_count = taken_count = 15 (saturated). Without the macro, both read 0.
